// File: rtl/ctrl_pkg.sv
// Shared types and constants for the I2S APB sequencer and its bus engine.
package ctrl_pkg;

  // Control word of the I2S core, kept opaque apart from the enable bit.
  typedef logic [31:0] OP_t;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_PREFILL,
    ST_EN,
    ST_RUN,
    ST_DIS,
    ST_DONE
  } seq_state_t;

  // What the access currently on the bus is for.
  typedef enum logic [2:0] {
    ACC_NONE,
    ACC_CFG,
    ACC_TX,
    ACC_RX,
    ACC_EN,
    ACC_DIS
  } acc_kind_t;

  // Register offsets relative to the core base address.
  localparam logic [31:0] REG_CTRL = 32'h0;
  localparam logic [31:0] REG_TX   = 32'h4;
  localparam logic [31:0] REG_RX   = 32'h8;

  // Return the control word with the transmit-enable bit forced to en.
  function automatic OP_t set_en(input OP_t word, input int en_bit, input logic en);
    OP_t res;
    res = word;
    res[en_bit[4:0]] = en;
    return res;
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// APB master engine: turns a req/addr/wr/wdata request into one SETUP plus
// one ACCESS cycle with no wait states. A new request may be accepted during
// the ACCESS cycle of the previous one, so accesses run back to back.
module apb_master_if (
  input  logic        pclk,
  input  logic        preset,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic        wr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata
);

  logic        psel_reg;
  logic        penable_reg;
  logic        pwrite_reg;
  logic [31:0] paddr_reg;
  logic [31:0] pwdata_reg;

  // Bus idle or in its last (ACCESS) cycle: a request now becomes the next SETUP.
  assign ready = !psel_reg || penable_reg;
  // ACCESS cycle: the transfer completes at the end of this cycle.
  assign ack   = psel_reg && penable_reg;
  assign rdata = prdata;

  assign psel    = psel_reg;
  assign penable = penable_reg;
  assign pwrite  = pwrite_reg;
  assign paddr   = paddr_reg;
  assign pwdata  = pwdata_reg;

  // SETUP/ACCESS sequencing; address and data are held after the access ends.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      psel_reg    <= 1'b0;
      penable_reg <= 1'b0;
      pwrite_reg  <= 1'b0;
      paddr_reg   <= '0;
      pwdata_reg  <= '0;
    end else if (ready && req) begin
      psel_reg    <= 1'b1;
      penable_reg <= 1'b0;
      pwrite_reg  <= wr;
      paddr_reg   <= addr;
      if (wr) begin
        pwdata_reg <= wdata;
      end
    end else if (psel_reg && !penable_reg) begin
      penable_reg <= 1'b1;
    end else begin
      psel_reg    <= 1'b0;
      penable_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/i2s_apb_sequencer.sv
// CPU-less APB master that configures an I2S core, prefills its TX FIFO,
// enables it, then streams TX writes and RX reads round-robin until stopped.
module i2s_apb_sequencer
  import ctrl_pkg::*;
#(
  parameter logic [31:0] OFFSET  = 32'h0,
  parameter int          PREFILL = 4,
  parameter int          EN_BIT  = 0
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] cfg_word,
  input  logic        tx_valid,
  input  logic [31:0] tx_data,
  output logic        tx_ready,
  input  logic        tx_full,
  input  logic        rx_empty,
  output logic        rx_valid,
  output logic [31:0] rx_data,
  output logic        running,
  output logic        done,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata
);

  localparam logic [3:0] PREFILL_N = 4'(PREFILL);

  seq_state_t  state_reg, state_next;
  OP_t         cfg_reg;
  logic [3:0]  cnt_reg;
  logic        rr_reg;        // 0: RX wins a tie next, 1: TX wins a tie next
  logic        stop_reg;
  logic        running_reg;
  logic        rx_valid_reg;
  logic [31:0] rx_data_reg;
  acc_kind_t   acc_reg;       // purpose of the access currently on the bus

  logic        ready, ack;
  logic [31:0] rdata;
  logic        req, req_wr;
  logic [31:0] req_addr, req_wdata;
  acc_kind_t   req_kind;

  logic        tx_ok, rx_ok, grant_rx, stop_pending, issue, ack_en, ack_dis;
  OP_t         cfg_off, cfg_on;

  assign tx_ok        = tx_valid && !tx_full;
  assign rx_ok        = !rx_empty;
  assign grant_rx     = rx_ok && (!tx_ok || !rr_reg);
  assign stop_pending = stop_reg || stop;
  assign issue        = req && ready;
  assign ack_en       = ack && (acc_reg == ACC_EN);
  assign ack_dis      = ack && (acc_reg == ACC_DIS);
  assign cfg_off      = set_en(cfg_reg, EN_BIT, 1'b0);
  assign cfg_on       = set_en(cfg_reg, EN_BIT, 1'b1);

  assign tx_ready = ack && (acc_reg == ACC_TX);
  assign running  = ack_en || (running_reg && !ack_dis);
  assign done     = (state_reg == ST_DONE);
  assign rx_valid = rx_valid_reg;
  assign rx_data  = rx_data_reg;

  apb_master_if u_apb (
    .pclk    (pclk),
    .preset  (preset),
    .req     (req),
    .addr    (req_addr),
    .wr      (req_wr),
    .wdata   (req_wdata),
    .ready   (ready),
    .ack     (ack),
    .rdata   (rdata),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata)
  );

  // State register.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a pending stop always diverts to the disable write.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (start) state_next = ST_CFG;
      ST_CFG:     if (issue) state_next = ST_PREFILL;
      ST_PREFILL: if (stop_pending) state_next = ST_DIS;
                  else if (cnt_reg == PREFILL_N) state_next = ST_EN;
      ST_EN:      if (stop_pending) state_next = ST_DIS;
                  else if (issue) state_next = ST_RUN;
      ST_RUN:     if (stop_pending) state_next = ST_DIS;
      ST_DIS:     if (ack_dis) state_next = ST_DONE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Bus request for the current state, including the RUN arbiter.
  always_comb begin
    req       = 1'b0;
    req_wr    = 1'b1;
    req_addr  = OFFSET + REG_CTRL;
    req_wdata = cfg_off;
    req_kind  = ACC_NONE;
    case (state_reg)
      ST_CFG: begin
        req      = 1'b1;
        req_kind = ACC_CFG;
      end
      ST_PREFILL: if (!stop_pending && cnt_reg < PREFILL_N && tx_ok) begin
        req       = 1'b1;
        req_addr  = OFFSET + REG_TX;
        req_wdata = tx_data;
        req_kind  = ACC_TX;
      end
      ST_EN: if (!stop_pending) begin
        req       = 1'b1;
        req_wdata = cfg_on;
        req_kind  = ACC_EN;
      end
      ST_RUN: if (!stop_pending) begin
        if (grant_rx) begin
          req      = 1'b1;
          req_wr   = 1'b0;
          req_addr = OFFSET + REG_RX;
          req_kind = ACC_RX;
        end else if (tx_ok) begin
          req       = 1'b1;
          req_addr  = OFFSET + REG_TX;
          req_wdata = tx_data;
          req_kind  = ACC_TX;
        end
      end
      // Keep requesting until the disable write itself is on the bus.
      ST_DIS: if (!(psel && acc_reg == ACC_DIS)) begin
        req      = 1'b1;
        req_kind = ACC_DIS;
      end
      default: ;
    endcase
  end

  // Sequencer bookkeeping: config latch, prefill count, arbiter pointer, stop latch.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      cfg_reg  <= '0;
      cnt_reg  <= '0;
      rr_reg   <= 1'b0;
      stop_reg <= 1'b0;
      acc_reg  <= ACC_NONE;
    end else begin
      if (state_reg == ST_IDLE && start) begin
        cfg_reg <= cfg_word;
        cnt_reg <= '0;
      end else if (state_reg == ST_PREFILL && issue) begin
        cnt_reg <= cnt_reg + 4'd1;
      end
      if (state_reg == ST_RUN && issue) begin
        rr_reg <= (req_kind == ACC_RX);
      end
      if (issue) begin
        acc_reg <= req_kind;
      end
      // Stop is only remembered once a run has been started, and is consumed by DIS.
      if (state_reg == ST_DIS) begin
        stop_reg <= 1'b0;
      end else if (state_reg == ST_IDLE) begin
        stop_reg <= start && stop;
      end else begin
        stop_reg <= stop_reg || stop;
      end
    end
  end

  // Running flag and RX capture at ACCESS completion.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      running_reg  <= 1'b0;
      rx_valid_reg <= 1'b0;
      rx_data_reg  <= '0;
    end else begin
      if (ack_en) begin
        running_reg <= 1'b1;
      end else if (ack_dis) begin
        running_reg <= 1'b0;
      end
      rx_valid_reg <= ack && (acc_reg == ACC_RX);
      if (ack && acc_reg == ACC_RX) begin
        rx_data_reg <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_i2s_apb_sequencer.sv
// Scenario bench for i2s_apb_sequencer: expected bus accesses are queued as
// stimulus is applied and compared with the accesses the monitor records.
module tb_i2s_apb_sequencer;

  localparam logic [31:0] OFF    = 32'h10;
  localparam logic [31:0] TX_INC = 32'h0101_0101;
  localparam logic [31:0] RX_INC = 32'h0111_1111;

  logic        pclk, preset, start, stop, tx_valid, tx_ready, tx_full, rx_empty;
  logic        rx_valid, running, done, psel, penable, pwrite;
  logic [31:0] cfg_word, tx_data, rx_data, paddr, pwdata, prdata;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
    int          cyc;
    logic        run;
    logic        txr;
    logic        stable;
  } acc_t;

  exp_t        exp_q[$];
  acc_t        obs_q[$];
  logic [31:0] rx_exp_q[$];
  logic [31:0] rx_data_q[$];
  int          rx_cyc_q[$];
  int          done_q[$];

  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  int          stray  = 0;
  int          tx_sent = 0;
  logic [31:0] rx_word;

  i2s_apb_sequencer #(.OFFSET(OFF), .PREFILL(4), .EN_BIT(0)) dut (
    .pclk(pclk), .preset(preset), .start(start), .stop(stop), .cfg_word(cfg_word),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .tx_full(tx_full),
    .rx_empty(rx_empty), .rx_valid(rx_valid), .rx_data(rx_data), .running(running),
    .done(done), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial forever begin
    @(posedge pclk);
    cyc++;
  end

  // Bus monitor: records completed accesses, rx_valid beats and done pulses.
  initial begin
    logic [31:0] s_addr, s_data;
    logic        s_wr;
    acc_t        a;
    s_addr = '0; s_data = '0; s_wr = 1'b0;
    forever begin
      @(negedge pclk);
      if (preset === 1'b1) begin
        if (psel && !penable) begin
          s_addr = paddr; s_wr = pwrite; s_data = pwdata;
        end
        if (psel && penable) begin
          a.addr = paddr; a.wr = pwrite; a.data = pwdata; a.cyc = cyc;
          a.run = running; a.txr = tx_ready;
          a.stable = (paddr === s_addr) && (pwrite === s_wr) && (!pwrite || pwdata === s_data);
          obs_q.push_back(a);
        end
        if (tx_ready && !(psel && penable && pwrite && paddr == OFF + 32'h4)) stray++;
        if (rx_valid) begin
          rx_data_q.push_back(rx_data);
          rx_cyc_q.push_back(cyc);
        end
        if (done) done_q.push_back(cyc);
      end
    end
  end

  // TX source: presents the next word once the current one is consumed.
  initial forever begin
    @(negedge pclk);
    if (tx_ready === 1'b1) begin
      tx_data = tx_data + TX_INC;
      tx_sent++;
    end
  end

  // RX responder: supplies read data from the SETUP of each RX read.
  initial forever begin
    @(negedge pclk);
    if (psel === 1'b1 && penable === 1'b0 && pwrite === 1'b0 && paddr == OFF + 32'h8) begin
      prdata = rx_word;
      rx_exp_q.push_back(rx_word);
      rx_word = rx_word + RX_INC;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    preset = 1'b0; start = 1'b0; stop = 1'b0; cfg_word = '0; tx_valid = 1'b0;
    tx_data = '0; tx_full = 1'b0; rx_empty = 1'b1; prdata = '0;
    repeat (3) @(negedge pclk);
    exp_q.delete(); obs_q.delete(); rx_exp_q.delete(); rx_data_q.delete();
    rx_cyc_q.delete(); done_q.delete();
    tx_sent = 0;
    rx_word = 32'hDEAD_BEEF;
    preset = 1'b1;
    @(posedge pclk); #1;
  endtask

  task automatic pulse_start(input logic [31:0] cfg, output int s);
    cfg_word = cfg; start = 1'b1; s = cyc;
    @(posedge pclk); #1;
    start = 1'b0;
  endtask

  task automatic wait_obs(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (obs_q.size() >= n) begin ok = 1'b1; break; end
      @(posedge pclk); #1;
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done_q.size() > 0) begin ok = 1'b1; break; end
      @(posedge pclk); #1;
    end
  endtask

  task automatic push_bringup(input logic [31:0] cfg, input logic [31:0] base);
    exp_q.push_back('{OFF, 1'b1, cfg & ~32'h1});
    for (int k = 0; k < 4; k++) exp_q.push_back('{OFF + 32'h4, 1'b1, base + TX_INC * k});
    exp_q.push_back('{OFF, 1'b1, cfg | 32'h1});
  endtask

  task automatic test_reset();
    int busy;
    preset = 1'b0; start = 1'b0; stop = 1'b0; tx_valid = 1'b1; tx_full = 1'b0;
    rx_empty = 1'b0; cfg_word = '0; tx_data = '0; prdata = '0;
    repeat (2) @(negedge pclk);
    checks++;
    if ({psel, penable, pwrite, tx_ready, rx_valid, running, done} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b, want 0000000", {psel, penable, pwrite, tx_ready, rx_valid, running, done});
    end
    checks++;
    if (paddr !== 32'h0 || pwdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_bus: got paddr=%h pwdata=%h, want 0", paddr, pwdata);
    end
    checks++;
    if (rx_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_rxdata: got %h, want 0", rx_data);
    end
    do_reset();
    tx_valid = 1'b1; rx_empty = 1'b0;
    busy = 0;
    repeat (10) begin
      @(negedge pclk);
      if (psel !== 1'b0 || running !== 1'b0) busy++;
    end
    checks++;
    if (busy !== 0) begin
      fails++;
      $display("FAIL idle_no_start: got %0d busy cycles, want 0", busy);
    end
  endtask

  task automatic test_bringup();
    int   s, n;
    bit   ok;
    exp_t e;
    acc_t o;
    do_reset();
    tx_valid = 1'b1; rx_empty = 1'b1; tx_data = 32'hA000_0000;
    push_bringup(32'h0000_0A02, 32'hA000_0000);
    pulse_start(32'h0000_0A02, s);
    wait_obs(6, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL bringup_timeout: got %0d accesses, want 6", obs_q.size());
      return;
    end
    for (int i = 0; i < 6; i++) begin
      o = obs_q[i];
      checks++;
      if (o.cyc !== s + 3 + 2 * i) begin
        fails++;
        $display("FAIL bringup_cycle%0d: got cycle %0d, want %0d", i, o.cyc, s + 3 + 2 * i);
      end
      checks++;
      if (o.run !== (i == 5) || o.txr !== (i >= 1 && i <= 4)) begin
        fails++;
        $display("FAIL bringup_flags%0d: got running=%b tx_ready=%b, want %b %b", i, o.run, o.txr, i == 5, i >= 1 && i <= 4);
      end
    end
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.addr !== e.addr || o.wr !== e.wr || o.data !== e.data || !o.stable) begin
        fails++;
        $display("FAIL bringup_acc%0d: got addr=%h wr=%b data=%h stable=%b, want addr=%h wr=%b data=%h",
                 n, o.addr, o.wr, o.data, o.stable, e.addr, e.wr, e.data);
      end
      n++;
    end
  endtask

  task automatic test_prefill_stall();
    int   s, n_tx, busy, n;
    bit   ok;
    exp_t e;
    acc_t o;
    do_reset();
    tx_valid = 1'b1; rx_empty = 1'b1; tx_data = 32'hB000_0000;
    push_bringup(32'h0000_0A02, 32'hB000_0000);
    pulse_start(32'h0000_0A02, s);
    n_tx = 0;
    for (int i = 0; i < 100 && n_tx < 2; i++) begin
      @(negedge pclk);
      if (tx_ready) n_tx++;
    end
    tx_full = 1'b1;
    busy = 0;
    repeat (8) begin
      @(negedge pclk);
      if (psel !== 1'b0 || tx_ready !== 1'b0) busy++;
    end
    checks++;
    if (n_tx !== 2 || busy !== 0) begin
      fails++;
      $display("FAIL stall_idle: got tx=%0d busy=%0d, want tx=2 busy=0", n_tx, busy);
    end
    tx_full = 1'b0;
    wait_obs(6, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL stall_timeout: got %0d accesses, want 6", obs_q.size());
      return;
    end
    checks++;
    if (obs_q[3].cyc - obs_q[2].cyc < 9) begin
      fails++;
      $display("FAIL stall_gap: got gap %0d cycles, want >= 9", obs_q[3].cyc - obs_q[2].cyc);
    end
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.addr !== e.addr || o.wr !== e.wr || o.data !== e.data || !o.stable) begin
        fails++;
        $display("FAIL stall_acc%0d: got addr=%h wr=%b data=%h, want addr=%h wr=%b data=%h",
                 n, o.addr, o.wr, o.data, e.addr, e.wr, e.data);
      end
      n++;
    end
  endtask

  task automatic test_run_arbitration();
    int   s, n;
    bit   ok;
    exp_t e;
    acc_t o;
    int   rd_cyc[4];
    do_reset();
    tx_valid = 1'b1; rx_empty = 1'b0; tx_data = 32'hC000_0000;
    push_bringup(32'h0000_0A02, 32'hC000_0000);
    for (int j = 0; j < 4; j++) begin
      exp_q.push_back('{OFF + 32'h8, 1'b0, 32'h0});
      exp_q.push_back('{OFF + 32'h4, 1'b1, 32'hC000_0000 + TX_INC * (4 + j)});
    end
    pulse_start(32'h0000_0A02, s);
    wait_obs(14, ok);
    repeat (2) @(posedge pclk);
    #1;
    checks++;
    if (!ok || rx_cyc_q.size() < 4 || rx_exp_q.size() < 4) begin
      fails++;
      $display("FAIL run_timeout: got %0d accesses %0d rx beats, want 14 and 4", obs_q.size(), rx_cyc_q.size());
      return;
    end
    for (int j = 0; j < 4; j++) rd_cyc[j] = obs_q[6 + 2 * j].cyc;
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.addr !== e.addr || o.wr !== e.wr || (e.wr && o.data !== e.data) || !o.stable) begin
        fails++;
        $display("FAIL run_acc%0d: got addr=%h wr=%b data=%h, want addr=%h wr=%b data=%h",
                 n, o.addr, o.wr, o.data, e.addr, e.wr, e.data);
      end
      n++;
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (rx_data_q[j] !== rx_exp_q[j] || rx_cyc_q[j] !== rd_cyc[j] + 1) begin
        fails++;
        $display("FAIL run_rx%0d: got data=%h cycle=%0d, want data=%h cycle=%0d",
                 j, rx_data_q[j], rx_cyc_q[j], rx_exp_q[j], rd_cyc[j] + 1);
      end
    end
  endtask

  task automatic test_stop();
    int   s, n0;
    bit   ok, hit;
    exp_t e;
    acc_t o;
    do_reset();
    tx_valid = 1'b1; rx_empty = 1'b1; tx_data = 32'hD000_0000;
    pulse_start(32'h0000_0A02, s);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge pclk);
      if (running && psel && !penable && pwrite && paddr == OFF + 32'h4) begin hit = 1'b1; break; end
    end
    checks++;
    if (!hit) begin
      fails++;
      $display("FAIL stop_setup_timeout: got no RUN TX setup, want one");
      return;
    end
    stop = 1'b1;
    n0 = obs_q.size();
    exp_q.push_back('{OFF + 32'h4, 1'b1, 32'hD000_0000 + TX_INC * tx_sent});
    exp_q.push_back('{OFF, 1'b1, 32'h0000_0A02});
    @(negedge pclk);
    stop = 1'b0;
    wait_done(ok);
    repeat (10) @(negedge pclk);
    checks++;
    if (!ok || obs_q.size() !== n0 + 2 || done_q.size() !== 1) begin
      fails++;
      $display("FAIL stop_count: got %0d accesses %0d done, want %0d and 1", obs_q.size(), done_q.size(), n0 + 2);
      return;
    end
    checks++;
    if (obs_q[n0].txr !== 1'b1 || obs_q[n0].run !== 1'b1 || obs_q[n0 + 1].run !== 1'b0) begin
      fails++;
      $display("FAIL stop_flags: got tx_ready=%b running=%b/%b, want 1 1/0", obs_q[n0].txr, obs_q[n0].run, obs_q[n0 + 1].run);
    end
    checks++;
    if (done_q[0] !== obs_q[n0 + 1].cyc + 1) begin
      fails++;
      $display("FAIL stop_done: got cycle %0d, want %0d", done_q[0], obs_q[n0 + 1].cyc + 1);
    end
    for (int i = 0; i < n0; i++) void'(obs_q.pop_front());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.addr !== e.addr || o.wr !== e.wr || o.data !== e.data) begin
        fails++;
        $display("FAIL stop_acc: got addr=%h data=%h, want addr=%h data=%h", o.addr, o.data, e.addr, e.data);
      end
    end
    checks++;
    if (psel !== 1'b0 || running !== 1'b0) begin
      fails++;
      $display("FAIL stop_idle: got psel=%b running=%b, want 0 0", psel, running);
    end
  endtask

  task automatic test_start_stop_same();
    bit ok;
    exp_t e;
    acc_t o;
    do_reset();
    tx_valid = 1'b1; rx_empty = 1'b0; tx_data = 32'hE000_0000;
    exp_q.push_back('{OFF, 1'b1, 32'h0000_0C06});
    exp_q.push_back('{OFF, 1'b1, 32'h0000_0C06});
    cfg_word = 32'h0000_0C07; start = 1'b1; stop = 1'b1;
    @(posedge pclk); #1;
    start = 1'b0; stop = 1'b0;
    wait_done(ok);
    repeat (5) @(negedge pclk);
    checks++;
    if (!ok || obs_q.size() !== 2 || tx_sent !== 0) begin
      fails++;
      $display("FAIL startstop_count: got %0d accesses tx=%0d, want 2 and 0", obs_q.size(), tx_sent);
      return;
    end
    checks++;
    if (done_q[0] !== obs_q[1].cyc + 1 || obs_q[0].run !== 1'b0 || obs_q[1].run !== 1'b0) begin
      fails++;
      $display("FAIL startstop_done: got done cycle %0d run=%b%b, want %0d 00", done_q[0], obs_q[0].run, obs_q[1].run, obs_q[1].cyc + 1);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.addr !== e.addr || o.wr !== e.wr || o.data !== e.data) begin
        fails++;
        $display("FAIL startstop_acc: got addr=%h data=%h, want addr=%h data=%h", o.addr, o.data, e.addr, e.data);
      end
    end
  endtask

  task automatic test_reset_mid();
    int   s, n;
    bit   ok, hit;
    exp_t e;
    acc_t o;
    do_reset();
    tx_valid = 1'b1; rx_empty = 1'b0; tx_data = 32'hF000_0000;
    pulse_start(32'h0000_0A02, s);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge pclk);
      if (psel && penable && !pwrite) begin hit = 1'b1; break; end
    end
    #2 preset = 1'b0;
    #1;
    checks++;
    if (!hit || {psel, penable, rx_valid, running} !== 4'b0) begin
      fails++;
      $display("FAIL async_reset: got hit=%b psel=%b penable=%b rx_valid=%b running=%b, want 1 0 0 0 0",
               hit, psel, penable, rx_valid, running);
    end
    do_reset();
    tx_valid = 1'b1; rx_empty = 1'b0; tx_data = 32'h5000_0000;
    push_bringup(32'h0000_0B04, 32'h5000_0000);
    pulse_start(32'h0000_0B04, s);
    wait_obs(6, ok);
    checks++;
    if (!ok || obs_q[0].cyc !== s + 3) begin
      fails++;
      $display("FAIL rerun_start: got %0d accesses first cycle %0d, want 6 at %0d", obs_q.size(), ok ? obs_q[0].cyc : -1, s + 3);
      return;
    end
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.addr !== e.addr || o.wr !== e.wr || o.data !== e.data) begin
        fails++;
        $display("FAIL rerun_acc%0d: got addr=%h data=%h, want addr=%h data=%h", n, o.addr, o.data, e.addr, e.data);
      end
      n++;
    end
  endtask

  task automatic test_start_in_run();
    int s, bad, last;
    bit ok;
    do_reset();
    tx_valid = 1'b1; rx_empty = 1'b0; tx_data = 32'h6000_0000;
    pulse_start(32'h0000_0A02, s);
    wait_obs(8, ok);
    pulse_start(32'hFFFF_FFFF, s);
    repeat (9) @(posedge pclk);
    #1 stop = 1'b1;
    @(posedge pclk); #1;
    stop = 1'b0;
    wait_done(ok);
    repeat (3) @(negedge pclk);
    checks++;
    if (!ok || obs_q.size() < 10) begin
      fails++;
      $display("FAIL startrun_timeout: got %0d accesses done=%b, want >= 10 and done", obs_q.size(), ok);
      return;
    end
    last = obs_q.size() - 1;
    bad = 0;
    for (int i = 6; i < last; i++) begin
      if (obs_q[i].addr == OFF) bad++;
      if (i == 6 && obs_q[i].wr !== 1'b0) bad++;
      if (i > 6 && obs_q[i].wr === obs_q[i - 1].wr) bad++;
    end
    checks++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL startrun_order: got %0d order errors, want 0", bad);
    end
    checks++;
    if (obs_q[last].addr !== OFF || obs_q[last].data !== 32'h0000_0A02) begin
      fails++;
      $display("FAIL startrun_cfg: got addr=%h data=%h, want addr=%h data=00000a02", obs_q[last].addr, obs_q[last].data, OFF);
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_prefill_stall();
    test_run_arbitration();
    test_stop();
    test_start_stop_same();
    test_reset_mid();
    test_start_in_run();
    checks++;
    if (stray !== 0) begin
      fails++;
      $display("FAIL tx_ready_stray: got %0d stray pulses, want 0", stray);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
